// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: packet-granular round-robin arbiter that feeds the
// single 8-bit AXI-Stream TX input of the MII MAC from NUM_PORTS sources.
//
// Ports:
//   clock, reset            TX clock, synchronous active-high reset
//   saxis_tdata/tvalid/     per-port AXIS inputs (port i at tdata[8i+7:8i])
//   tready/tlast
//   maxis_tdata/tvalid/     AXIS output towards the MAC
//   tready/tlast
//   grant                   one-hot owner, zero while idle
//   truncated               one-cycle pulse when a frame is cut
//
// Frames longer than MAX_FRAME_BYTES get a forced tlast; the rest of the
// input frame is drained and discarded.
// Optional macro ETH_TX_ARB_STRICT_PRIO_EN: fixed priority, lowest wins.
module eth_tx_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [8*NUM_PORTS-1:0] saxis_tdata,
  input  logic [NUM_PORTS-1:0]   saxis_tvalid,
  output logic [NUM_PORTS-1:0]   saxis_tready,
  input  logic [NUM_PORTS-1:0]   saxis_tlast,
  output logic [7:0]             maxis_tdata,
  output logic                   maxis_tvalid,
  input  logic                   maxis_tready,
  output logic                   maxis_tlast,
  output logic [NUM_PORTS-1:0]   grant,
  output logic                   truncated
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [CW-1:0] CNT_END = CW'(MAX_FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DRAIN
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] g, g_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          trunc_nxt;

  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          pick_vld;
  logic [IW+2:0] base;
  logic [7:0]    sel_data;
  logic          sel_valid;
  logic          sel_last;
  logic          at_limit;

`ifndef ETH_TX_ARB_STRICT_PRIO_EN
  logic [IW-1:0] last;

  always_ff @(posedge clock) begin
    if (reset) begin
      last <= IW'(NUM_PORTS - 1);
    end else if (state == IDLE && pick_vld) begin
      last <= pick;
    end
  end
`endif

  // Loops run from lowest to highest priority so the last hit wins.
  always_comb begin
    pick     = '0;
    cand     = '0;
    pick_vld = 1'b0;
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = IW'(k);
      if (saxis_tvalid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
`else
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NUM_PORTS);
      if (saxis_tvalid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
`endif
  end

  assign base      = {g, 3'b000};
  assign sel_data  = saxis_tdata[base +: 8];
  assign sel_valid = saxis_tvalid[g];
  assign sel_last  = saxis_tlast[g];
  assign at_limit  = (cnt == CNT_END);

  always_comb begin
    state_nxt    = state;
    g_nxt        = g;
    cnt_nxt      = cnt;
    trunc_nxt    = 1'b0;
    maxis_tdata  = '0;
    maxis_tvalid = 1'b0;
    maxis_tlast  = 1'b0;
    saxis_tready = '0;
    grant        = '0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          g_nxt     = pick;
          cnt_nxt   = '0;
          state_nxt = PASS;
        end
      end
      PASS: begin
        grant[g]        = 1'b1;
        maxis_tdata     = sel_data;
        maxis_tvalid    = sel_valid;
        maxis_tlast     = sel_last | at_limit;
        saxis_tready[g] = maxis_tready;
        if (sel_valid && maxis_tready) begin
          cnt_nxt = cnt + CW'(1);
          // A real tlast on the limit byte ends cleanly, no cut.
          if (sel_last) begin
            state_nxt = IDLE;
          end else if (at_limit) begin
            state_nxt = DRAIN;
            trunc_nxt = 1'b1;
          end
        end
      end
      DRAIN: begin
        grant[g]        = 1'b1;
        maxis_tdata     = sel_data;
        saxis_tready[g] = 1'b1;
        if (sel_valid && sel_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      g         <= '0;
      cnt       <= '0;
      truncated <= 1'b0;
    end else begin
      state     <= state_nxt;
      g         <= g_nxt;
      cnt       <= cnt_nxt;
      truncated <= trunc_nxt;
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: self-checking bench for eth_tx_arbiter
// (NUM_PORTS=4, MAX_FRAME_BYTES=64).
module tb_eth_tx_arbiter;

  localparam int NP   = 4;
  localparam int MAXB = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic [8*NP-1:0] saxis_tdata;
  logic [NP-1:0]   saxis_tvalid;
  logic [NP-1:0]   saxis_tready;
  logic [NP-1:0]   saxis_tlast;
  logic [7:0]      maxis_tdata;
  logic            maxis_tvalid;
  logic            maxis_tready;
  logic            maxis_tlast;
  logic [NP-1:0]   grant;
  logic            truncated;

  always #5 clock = ~clock;

  eth_tx_arbiter #(
    .NUM_PORTS      (NP),
    .MAX_FRAME_BYTES(MAXB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .saxis_tdata (saxis_tdata),
    .saxis_tvalid(saxis_tvalid),
    .saxis_tready(saxis_tready),
    .saxis_tlast (saxis_tlast),
    .maxis_tdata (maxis_tdata),
    .maxis_tvalid(maxis_tvalid),
    .maxis_tready(maxis_tready),
    .maxis_tlast (maxis_tlast),
    .grant       (grant),
    .truncated   (truncated)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       last;
    logic       first;
  } exp_t;

  typedef struct {
    int port;
    int len;
    bit toggle;
    int exp_beats;
    int exp_trunc;
    int exp_drain;
  } vec_t;

  beat_t src_q [NP][$];
  exp_t  exp_q [$];
  int    starts [$];
  int    in_last_cyc [NP];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int frame_id = 0;
  int trunc_cnt, drain_cnt, beat_cnt;
  bit toggle_rdy = 1'b0;
  bit rst_req = 1'b0;
  logic [NP-1:0] acc;
  logic [NP-1:0] s_grant, s_sready;
  logic          s_mvalid, s_trunc;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic add_frame(input int port, input int len);
    int    n;
    beat_t b;
    exp_t  e;
    n = (len < MAXB) ? len : MAXB;
    frame_id++;
    for (int j = 0; j < len; j++) begin
      b.data = 8'(frame_id * 37 + j * 3);
      b.last = (j == len - 1);
      src_q[port].push_back(b);
      if (j < n) begin
        e.port  = port;
        e.data  = b.data;
        e.last  = (j == n - 1);
        e.first = (j == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive();
    reset = rst_req;
    maxis_tready = rst_req ? 1'b0 : (toggle_rdy ? (cyc % 2 == 0) : 1'b1);
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() != 0) begin
        saxis_tvalid[i]       = 1'b1;
        saxis_tdata[8*i +: 8] = src_q[i][0].data;
        saxis_tlast[i]        = src_q[i][0].last;
      end else begin
        saxis_tvalid[i]       = 1'b0;
        saxis_tdata[8*i +: 8] = 8'($urandom);
        saxis_tlast[i]        = 1'($urandom);
      end
    end
  endtask

  task automatic observe();
    exp_t e;
    s_grant  = grant;
    s_mvalid = maxis_tvalid;
    s_sready = saxis_tready;
    s_trunc  = truncated;
    acc      = saxis_tvalid & saxis_tready;
    check("ready_leak", saxis_tready & ~grant, 0);
    if (grant == '0) check("idle_valid", maxis_tvalid, 0);
    if (maxis_tvalid) begin
      check("ready_mirror", saxis_tready, maxis_tready ? grant : '0);
    end
    if (truncated) trunc_cnt++;
    if (!maxis_tvalid) begin
      for (int i = 0; i < NP; i++) if (acc[i]) drain_cnt++;
    end
    if (maxis_tvalid && maxis_tready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("data", maxis_tdata, e.data);
        check("last", maxis_tlast, e.last);
        check("grant", grant, 1 << e.port);
        beat_cnt++;
        if (e.first) starts.push_back(cyc);
      end
    end
  endtask

  task automatic cycle();
    drive();
    #1;
    observe();
    @(posedge clock);
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) begin
        if (src_q[i][0].last) in_last_cyc[i] = cyc;
        void'(src_q[i].pop_front());
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic run_done(input int budget);
    int n;
    n = 0;
    while ((!srcs_empty() || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("timeout", n >= budget, 0);
    cycle();
    check("back_to_idle", s_grant, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   n;
    vecs[0] = '{2, 64, 1'b1, 64, 0, 0};
    vecs[1] = '{1, 100, 1'b0, 64, 1, 36};
    vecs[2] = '{0, 64, 1'b0, 64, 0, 0};
    vecs[3] = '{3, 1, 1'b0, 1, 0, 0};
    vecs[4] = '{0, 65, 1'b1, 64, 1, 1};
    vecs[5] = '{1, 63, 1'b0, 63, 0, 0};

    reset        = 1'b1;
    maxis_tready = 1'b0;
    saxis_tvalid = '0;
    saxis_tdata  = '0;
    saxis_tlast  = '0;
    trunc_cnt    = 0;
    drain_cnt    = 0;
    beat_cnt     = 0;
    repeat (3) @(negedge clock);

    cycle();
    check("rst_grant0", s_grant, 0);
    check("rst_mvalid0", s_mvalid, 0);
    check("rst_sready0", s_sready, 0);
    check("rst_trunc0", s_trunc, 0);

`ifndef ETH_TX_ARB_STRICT_PRIO_EN
    starts.delete();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NP; p++) add_frame(p, 10);
    end
    run_done(400);
    check("rr_frames", starts.size(), 8);
    for (int k = 1; k < starts.size(); k++) begin
      check("rr_gap", starts[k] - starts[k-1], 11);
    end
`else
    starts.delete();
    for (int r = 0; r < 3; r++) add_frame(0, 8);
    for (int r = 0; r < 3; r++) add_frame(1, 8);
    run_done(400);
    check("prio_frames", starts.size(), 6);
`endif

    for (int i = 0; i < 6; i++) begin
      toggle_rdy = vecs[i].toggle;
      trunc_cnt  = 0;
      drain_cnt  = 0;
      beat_cnt   = 0;
      add_frame(vecs[i].port, vecs[i].len);
      run_done(1000);
      check("vec_beats", beat_cnt, vecs[i].exp_beats);
      check("vec_trunc", trunc_cnt, vecs[i].exp_trunc);
      check("vec_drain", drain_cnt, vecs[i].exp_drain);
    end
    toggle_rdy = 1'b0;

    starts.delete();
    trunc_cnt = 0;
    add_frame(1, 100);
    cycle();
    add_frame(2, 5);
    run_done(1000);
    check("trunc_once", trunc_cnt, 1);
    check("trunc_frames", starts.size(), 2);
    if (starts.size() == 2) begin
      check("next_after_tlast", starts[1], in_last_cyc[1] + 2);
    end

    beat_cnt = 0;
    add_frame(3, 20);
    n = 0;
    while (beat_cnt < 5 && n < 200) begin
      cycle();
      n++;
    end
    check("rst_wait", n >= 200, 0);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    exp_q.delete();
    starts.delete();
    add_frame(0, 5);
    add_frame(3, 5);
    cycle();
    check("midrst_grant", s_grant, 0);
    check("midrst_mvalid", s_mvalid, 0);
    check("midrst_sready", s_sready, 0);
    run_done(200);
    check("midrst_frames", starts.size(), 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
